// File: rtl/rst_pkg.sv
// -----------------------------------------------------------------------------
// rst_pkg
// Shared definitions for the reset-sink block: FSM state encoding, the
// polarity keyword, default qualification/hold lengths and a helper that
// sizes the qualification/hold counter.
// No ports.
// -----------------------------------------------------------------------------
package rst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        QUAL   = 2'b01,
        ACTIVE = 2'b10,
        HOLD   = 2'b11
    } rst_sink_state_t;

    // ACTIVE_HIGH parameter value that selects a high-asserting rst_in
    localparam string RST_POL_HIGH = "YES";

    localparam int RST_MIN_LEN_DEF  = 4;
    localparam int RST_HOLD_LEN_DEF = 16;

    // Counter must hold the larger of the two lengths
    function automatic int rst_cnt_w(input int min_len, input int hold_len);
        int mx;
        mx = (min_len > hold_len) ? min_len : hold_len;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// -----------------------------------------------------------------------------
// rst_sync_chain
// Plain flop chain used to bring an asynchronous level into the clk domain.
// On rst every stage loads RST_VAL so the chain comes up holding a known
// (normally the deasserted) level.
//
// Ports:
//   clk  - sampling clock
//   rst  - synchronous, active-high reset of the chain
//   d    - asynchronous input level
//   q    - synchronized level, STAGES cycles behind d
// -----------------------------------------------------------------------------
module rst_sync_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {STAGES{RST_VAL}};
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/rst_sink.sv
// -----------------------------------------------------------------------------
// rst_sink
// Receiving end of the reset distribution path. Synchronizes a raw reset
// request of configurable polarity, rejects requests shorter than MIN_LEN
// samples and stretches accepted requests by HOLD_LEN cycles. Drives a clean,
// registered, active-high rst_out plus status.
//
// Build option:
//   RST_SINK_SYNC_EN  defined   -> rst_in passes through a SYNC_STAGES-deep
//                                  synchronizer.
//                     undefined -> rst_in is taken as already synchronous to
//                                  clk; SYNC_STAGES is not used.
//
// Ports:
//   clk      - single clock for the whole block
//   rst      - block reset, synchronous, active-high
//   rst_in   - raw reset request, polarity set by ACTIVE_HIGH
//   rst_out  - conditioned reset, synchronous, active-high, registered
//   ready    - high when rst_out is low and the FSM is idle
//   glitch   - one-cycle pulse when a request is rejected as too short
//   evt_cnt  - saturating count of accepted requests
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no request; rst_out low, ready high
// QUAL   | request seen, counting consecutive asserted samples
// ACTIVE | request accepted; rst_out high while the request persists
// HOLD   | request released; rst_out stretched for HOLD_LEN cycles
// -----------------------------------------------------------------------------
module rst_sink
    import rst_pkg::*;
#(
    parameter string ACTIVE_HIGH = "YES",
    parameter int    SYNC_STAGES = 2,
    parameter int    MIN_LEN     = RST_MIN_LEN_DEF,
    parameter int    HOLD_LEN    = RST_HOLD_LEN_DEF,
    parameter int    CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_in,
    output logic             rst_out,
    output logic             ready,
    output logic             glitch,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam bit POL_HIGH = (ACTIVE_HIGH == RST_POL_HIGH);
    localparam int CW       = rst_cnt_w(MIN_LEN, HOLD_LEN);

    localparam logic [CW-1:0]    MIN_C  = CW'(MIN_LEN);
    localparam logic [CW-1:0]    HOLD_C = CW'(HOLD_LEN);
    localparam logic [CW-1:0]    CNT_1  = CW'(1);
    localparam logic [CNT_W-1:0] EVT_MAX = {CNT_W{1'b1}};

    logic raw_s;
    logic req;

`ifdef RST_SINK_SYNC_EN
    // Chain resets to the deasserted level so that leaving rst never looks
    // like a fresh request.
    localparam logic IDLE_LVL = POL_HIGH ? 1'b0 : 1'b1;

    rst_sync_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (IDLE_LVL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rst_in),
        .q   (raw_s)
    );
`else
    assign raw_s = rst_in;
`endif

    assign req = POL_HIGH ? raw_s : ~raw_s;

    rst_sink_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            evt_inc;
    logic            glitch_d;

    logic             rst_out_q;
    logic             ready_q;
    logic             glitch_q;
    logic [CNT_W-1:0] evt_q;

    assign cnt_inc = cnt_q + CNT_1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        evt_inc  = 1'b0;
        glitch_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (MIN_LEN == 1) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                        evt_inc = 1'b1;
                    end else begin
                        state_d = QUAL;
                        cnt_d   = CNT_1;
                    end
                end
            end

            QUAL: begin
                if (req) begin
                    // cnt_q holds the samples counted so far; this one makes cnt_inc
                    if (cnt_inc >= MIN_C) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                        evt_inc = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end
            end

            ACTIVE: begin
                if (!req) begin
                    state_d = HOLD;
                    cnt_d   = CNT_1;
                end
            end

            HOLD: begin
                // Re-assertion while stretching continues the same event
                if (req) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else if (cnt_q >= HOLD_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state so that rst_out and ready
    // change on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
            glitch_q  <= 1'b0;
            evt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= (state_d == ACTIVE) || (state_d == HOLD);
            ready_q   <= (state_d == IDLE);
            glitch_q  <= glitch_d;
            if (evt_inc && (evt_q != EVT_MAX)) begin
                evt_q <= evt_q + CNT_W'(1);
            end
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign glitch  = glitch_q;
    assign evt_cnt = evt_q;

endmodule

// File: tb/tb_rst_sink.sv
module tb_rst_sink;

    localparam int MIN_LEN  = 4;
    localparam int HOLD_LEN = 16;
`ifdef RST_SINK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    // event kinds
    localparam int K_RISE   = 0;
    localparam int K_FALL   = 1;
    localparam int K_GLITCH = 2;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic rst_in   = 1'b0;
    logic rst_in_n = 1'b1;

    logic       rst_out0, ready0, glitch0;
    logic [7:0] evt0;
    logic       rst_out_s, ready_s, glitch_s;
    logic [1:0] evt_s;
    logic       rst_out_n, ready_n, glitch_n;
    logic [7:0] evt_n;

    rst_sink dut0 (
        .clk(clk), .rst(rst), .rst_in(rst_in),
        .rst_out(rst_out0), .ready(ready0), .glitch(glitch0), .evt_cnt(evt0)
    );

    rst_sink #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .rst_in(rst_in),
        .rst_out(rst_out_s), .ready(ready_s), .glitch(glitch_s), .evt_cnt(evt_s)
    );

    rst_sink #(.ACTIVE_HIGH("NO")) dut_neg (
        .clk(clk), .rst(rst), .rst_in(rst_in_n),
        .rst_out(rst_out_n), .ready(ready_n), .glitch(glitch_n), .evt_cnt(evt_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int edge_no;
        int evt;
    } ev_t;

    ev_t q0[$];
    ev_t qn[$];

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    logic prev0  = 1'b1;
    logic prevn  = 1'b1;
    int   m_evt0 = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push0(input int k, input int e, input int v);
        ev_t x;
        x.kind = k; x.edge_no = e; x.evt = v;
        q0.push_back(x);
    endtask

    task automatic pushn(input int k, input int e, input int v);
        ev_t x;
        x.kind = k; x.edge_no = e; x.evt = v;
        qn.push_back(x);
    endtask

    // Monitor for dut0: any rst_out edge or glitch pulse is an output event
    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (mon_en && ((rst_out0 !== prev0) || (glitch0 === 1'b1))) begin
            k = (glitch0 === 1'b1) ? K_GLITCH : ((rst_out0 === 1'b1) ? K_RISE : K_FALL);
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut0_unexpected: event kind %0d at edge %0d, none expected", k, cyc);
            end else begin
                e = q0.pop_front();
                chk("dut0_kind", k, e.kind);
                chk("dut0_edge", cyc, e.edge_no);
                chk("dut0_evt_cnt", int'(evt0), e.evt);
                chk("dut0_ready", int'(ready0), (e.kind == K_RISE) ? 0 : 1);
            end
        end
        if (mon_en) prev0 = rst_out0;
    end

    // Monitor for the low-asserting instance
    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (mon_en && ((rst_out_n !== prevn) || (glitch_n === 1'b1))) begin
            k = (glitch_n === 1'b1) ? K_GLITCH : ((rst_out_n === 1'b1) ? K_RISE : K_FALL);
            if (qn.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL neg_unexpected: event kind %0d at edge %0d, none expected", k, cyc);
            end else begin
                e = qn.pop_front();
                chk("neg_kind", k, e.kind);
                chk("neg_edge", cyc, e.edge_no);
                chk("neg_evt_cnt", int'(evt_n), e.evt);
                chk("neg_ready", int'(ready_n), (e.kind == K_RISE) ? 0 : 1);
            end
        end
        if (mon_en) prevn = rst_out_n;
    end

    // Single assertion of n samples on rst_in; called at a negedge.
    task automatic pulse(input int n);
        int c;
        c = cyc;
        rst_in = 1'b1;
        if (n >= MIN_LEN) begin
            if (m_evt0 < 255) m_evt0++;
            push0(K_RISE, c + LAT + MIN_LEN, m_evt0);
            push0(K_FALL, c + n + 1 + LAT + HOLD_LEN, m_evt0);
        end else begin
            push0(K_GLITCH, c + n + 1 + LAT, m_evt0);
        end
        repeat (n) @(negedge clk);
        rst_in = 1'b0;
        repeat (LAT + HOLD_LEN + 6) @(negedge clk);
    endtask

    // 10 asserted, 5 released, 6 asserted again: one event, one long rst_out
    task automatic reassert_in_hold();
        int c;
        c = cyc;
        rst_in = 1'b1;
        if (m_evt0 < 255) m_evt0++;
        push0(K_RISE, c + LAT + MIN_LEN, m_evt0);
        push0(K_FALL, c + 22 + LAT + HOLD_LEN, m_evt0);
        repeat (10) @(negedge clk);
        rst_in = 1'b0;
        repeat (5) @(negedge clk);
        rst_in = 1'b1;
        repeat (6) @(negedge clk);
        rst_in = 1'b0;
        repeat (LAT + HOLD_LEN + 6) @(negedge clk);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_rst_out", int'(rst_out0), 1);
        chk("rst_ready", int'(ready0), 0);
        chk("rst_glitch", int'(glitch0), 0);
        chk("rst_evt_cnt", int'(evt0), 0);
        chk("rst_sat_evt_cnt", int'(evt_s), 0);
        chk("rst_neg_rst_out", int'(rst_out_n), 1);

        // power-on stretch: 16 more cycles high, low after edge 3+17
        push0(K_FALL, cyc + HOLD_LEN + 1, 0);
        pushn(K_FALL, cyc + HOLD_LEN + 1, 0);
        prev0  = 1'b1;
        prevn  = 1'b1;
        mon_en = 1'b1;
        repeat (HOLD_LEN + 4) @(negedge clk);

        pulse(10);
        pulse(3);
        pulse(MIN_LEN);
        reassert_in_hold();
        pulse(5);
        pulse(6);
        pulse(MIN_LEN);

        // low-asserting instance, 4 low samples
        c = cyc;
        rst_in_n = 1'b0;
        pushn(K_RISE, c + LAT + 4, 1);
        pushn(K_FALL, c + 5 + LAT + HOLD_LEN, 1);
        repeat (4) @(negedge clk);
        rst_in_n = 1'b1;
        repeat (LAT + HOLD_LEN + 6) @(negedge clk);

        chk("dut0_pending_events", q0.size(), 0);
        chk("neg_pending_events", qn.size(), 0);
        chk("dut0_final_evt_cnt", int'(evt0), 6);
        chk("sat_final_evt_cnt", int'(evt_s), 3);
        chk("neg_final_evt_cnt", int'(evt_n), 1);
        chk("dut0_final_ready", int'(ready0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
